// File: rtl/rx_packet_framer.sv
// Purpose: assembles two UART bytes (address, then command) into one request packet.
// Latency: pkt_valid rises 1 cycle after the command byte's rx_done.
// Backpressure: the packet is held until pkt_valid & pkt_ready; bytes arriving meanwhile are dropped and flagged.
//
// Ports:
//   clock, reset_n          - system clock, async active-low reset
//   rx_done, rx_data        - byte strobe and byte from UART_RX
//   pkt_ready               - consumer accepts the packet when high with pkt_valid
//   pkt_valid, pkt_address, pkt_command - packet handshake and payload
//   timeout_err             - 1-cycle pulse: half-received packet discarded
//   overrun_err             - 1-cycle pulse: byte dropped while a packet was pending
module rx_packet_framer #(
  parameter int TIMEOUT_CYCLES = 500000,
  parameter int CNT_W          = 19
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  input  logic       pkt_ready,
  output logic       pkt_valid,
  output logic [7:0] pkt_address,
  output logic [7:0] pkt_command,
  output logic       timeout_err,
  output logic       overrun_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_CMD = 2'd1,
    HOLD     = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] timeout_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      timeout_cnt <= '0;
      pkt_valid   <= 1'b0;
      pkt_address <= 8'h00;
      pkt_command <= 8'h00;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      // Error outputs are single-cycle pulses by default.
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;

      case (state)
        IDLE: begin
          if (rx_done) begin
            pkt_address <= rx_data;
            timeout_cnt <= '0;
            state       <= WAIT_CMD;
          end
        end

        WAIT_CMD: begin
          // The byte is checked first so a byte arriving on the last
          // allowed cycle still completes the packet.
          if (rx_done) begin
            pkt_command <= rx_data;
            pkt_valid   <= 1'b1;
            state       <= HOLD;
          end else if (timeout_cnt == TIMEOUT_LAST) begin
            // pkt_address keeps the stale byte; it is only meaningful
            // while pkt_valid is high.
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            // Increment only below the limit, so the counter cannot wrap.
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end

        HOLD: begin
          if (pkt_ready) begin
            pkt_valid <= 1'b0;
            if (rx_done) begin
              // Slot frees on this edge, so the byte starts the next packet.
              pkt_address <= rx_data;
              timeout_cnt <= '0;
              state       <= WAIT_CMD;
            end else begin
              state <= IDLE;
            end
          end else if (rx_done) begin
            overrun_err <= 1'b1;
          end
        end

        default: begin
          pkt_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_packet_framer.sv
// Purpose: directed self-checking bench for rx_packet_framer (TIMEOUT_CYCLES = 16).
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: pkt_ready driven per scenario to exercise hold, overrun and same-cycle reuse.
module tb_rx_packet_framer;

  localparam int TO = 16;

  logic       clock;
  logic       reset_n;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       pkt_ready;
  logic       pkt_valid;
  logic [7:0] pkt_address;
  logic [7:0] pkt_command;
  logic       timeout_err;
  logic       overrun_err;

  int n_checks = 0;
  int n_pass   = 0;

  // Pulse monitors, updated just after each rising edge.
  int to_cnt   = 0;
  int ov_cnt   = 0;
  int both_cnt = 0;
  int vld_cyc  = 0;

  rx_packet_framer #(
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (5)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .rx_done    (rx_done),
    .rx_data    (rx_data),
    .pkt_ready  (pkt_ready),
    .pkt_valid  (pkt_valid),
    .pkt_address(pkt_address),
    .pkt_command(pkt_command),
    .timeout_err(timeout_err),
    .overrun_err(overrun_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    #1;
    if (timeout_err) to_cnt++;
    if (overrun_err) ov_cnt++;
    if (timeout_err && overrun_err) both_cnt++;
    if (pkt_valid) vld_cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Called at a falling edge; returns at the falling edge after the capturing rising edge.
  task automatic send_byte(input logic [7:0] b);
    rx_done = 1'b1;
    rx_data = b;
    @(negedge clock);
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  int idle_bad;
  int to0, ov0, vld0;

  initial begin
    reset_n   = 1'b0;
    rx_done   = 1'b0;
    rx_data   = 8'h00;
    pkt_ready = 1'b0;

    // Reset then idle
    idle(3);
    check("rst_valid", 32'(pkt_valid), 32'h0);
    check("rst_addr", 32'(pkt_address), 32'h0);
    reset_n  = 1'b1;
    idle_bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (pkt_valid || timeout_err || overrun_err || pkt_address != 8'h00 || pkt_command != 8'h00)
        idle_bad++;
    end
    check("idle_quiet", 32'(idle_bad), 32'h0);

    // Normal packet with pkt_ready held high (gap kept inside the 16-cycle timeout)
    pkt_ready = 1'b1;
    send_byte(8'hA1);
    idle(10);
    vld0 = vld_cyc;
    send_byte(8'h03);
    check("norm_valid", 32'(pkt_valid), 32'h1);
    check("norm_addr", 32'(pkt_address), 32'hA1);
    check("norm_cmd", 32'(pkt_command), 32'h03);
    @(negedge clock);
    check("norm_valid_drop", 32'(pkt_valid), 32'h0);
    check("norm_one_cycle", 32'(vld_cyc - vld0), 32'h1);
    check("norm_no_err", 32'(to_cnt + ov_cnt), 32'h0);
    pkt_ready = 1'b0;

    // Backpressure and overrun
    send_byte(8'h10);
    send_byte(8'h20);
    idle(3);
    check("bp_valid", 32'(pkt_valid), 32'h1);
    ov0 = ov_cnt;
    send_byte(8'h55);
    check("ovr_pulse", 32'(overrun_err), 32'h1);
    @(negedge clock);
    check("ovr_pulse_end", 32'(overrun_err), 32'h0);
    check("ovr_once", 32'(ov_cnt - ov0), 32'h1);
    check("bp_addr", 32'(pkt_address), 32'h10);
    check("bp_cmd", 32'(pkt_command), 32'h20);
    pkt_ready = 1'b1;
    @(negedge clock);
    pkt_ready = 1'b0;
    check("bp_xfer_done", 32'(pkt_valid), 32'h0);

    // Timeout: error on the 16th edge after the address byte
    to0  = to_cnt;
    vld0 = vld_cyc;
    send_byte(8'h01);
    idle(TO - 1);
    check("to_not_early", 32'(timeout_err), 32'h0);
    @(negedge clock);
    check("to_pulse", 32'(timeout_err), 32'h1);
    @(negedge clock);
    check("to_pulse_end", 32'(timeout_err), 32'h0);
    check("to_once", 32'(to_cnt - to0), 32'h1);
    check("to_no_valid", 32'(vld_cyc - vld0), 32'h0);
    send_byte(8'h02);
    send_byte(8'h04);
    check("to_next_addr", 32'(pkt_address), 32'h02);
    check("to_next_cmd", 32'(pkt_command), 32'h04);
    pkt_ready = 1'b1;
    @(negedge clock);
    pkt_ready = 1'b0;

    // Boundary: command byte on the cycle the counter equals TIMEOUT_CYCLES-1
    to0 = to_cnt;
    send_byte(8'h33);
    idle(TO - 1);
    send_byte(8'h44);
    check("bnd_valid", 32'(pkt_valid), 32'h1);
    check("bnd_cmd", 32'(pkt_command), 32'h44);
    check("bnd_no_to", 32'(to_cnt - to0), 32'h0);

    // Transfer and new byte in the same cycle
    ov0       = ov_cnt;
    pkt_ready = 1'b1;
    send_byte(8'h77);
    pkt_ready = 1'b0;
    check("reuse_valid_drop", 32'(pkt_valid), 32'h0);
    check("reuse_no_ovr", 32'(ov_cnt - ov0), 32'h0);
    send_byte(8'h88);
    check("reuse_addr", 32'(pkt_address), 32'h77);
    check("reuse_cmd", 32'(pkt_command), 32'h88);
    pkt_ready = 1'b1;
    @(negedge clock);
    pkt_ready = 1'b0;

    // Reset mid-packet, asserted between clock edges
    to0 = to_cnt;
    ov0 = ov_cnt;
    send_byte(8'hAA);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_addr", 32'(pkt_address), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    send_byte(8'hBB);
    send_byte(8'hCC);
    check("mid_rst_valid", 32'(pkt_valid), 32'h1);
    check("mid_rst_pkt", 32'({pkt_address, pkt_command}), 32'hBBCC);
    check("mid_rst_no_err", 32'((to_cnt - to0) + (ov_cnt - ov0)), 32'h0);
    pkt_ready = 1'b1;
    @(negedge clock);
    pkt_ready = 1'b0;

    check("errs_exclusive", 32'(both_cnt), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
